// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: the
// controller state encoding, datapath widths and the hardwired-zero
// register index.
package mul_pkg;

    localparam int DATA_W    = 32;
    localparam int ITER      = 32;
    localparam int REG_IDX_W = 5;

    // Register file entry 0 reads as zero, so a write to it is suppressed.
    localparam logic [REG_IDX_W-1:0] R0 = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq_unit_if.sv
// Operand/writeback bundle between the register file side (master) and
// the multiplier (slave). Names follow the register file port naming:
// PA/PB read data, PC write data, SC write select, RFL write strobe.
interface mul_seq_unit_if #(
    parameter int DATA_W = 32
);
    logic                              in_start;
    logic [DATA_W-1:0]                 in_PA;
    logic [DATA_W-1:0]                 in_PB;
    logic [mul_pkg::REG_IDX_W-1:0]     in_SC;
    logic                              in_signed;
    logic [DATA_W-1:0]                 out_PC;
    logic [mul_pkg::REG_IDX_W-1:0]     out_SC;
    logic                              out_RFL;
    logic                              out_busy;
    logic                              out_done;
    logic                              out_ovf;

    modport master (
        output in_start, in_PA, in_PB, in_SC, in_signed,
        input  out_PC, out_SC, out_RFL, out_busy, out_done, out_ovf
    );

    modport slave (
        input  in_start, in_PA, in_PB, in_SC, in_signed,
        output out_PC, out_SC, out_RFL, out_busy, out_done, out_ovf
    );
endinterface

// File: rtl/mul_shift_add_core.sv
// Shift-add datapath: 65-bit product register {carry, high, low},
// 33-bit adder and iteration counter. One iteration per cycle while
// step is high. prod_next is the product after the current iteration, so
// the controller can register the final result on the same edge that
// performs the last iteration.
module mul_shift_add_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     mcand,
    input  logic [DATA_W-1:0]     mplier,
    output logic [2*DATA_W-1:0]   prod_next,
    output logic                  last
);

    logic [2*DATA_W:0] p_q, p_d, p_step_s;
    logic [DATA_W:0]   sum_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // One add-then-shift iteration, and the next-state selection.
    always_comb begin
        if (p_q[0]) begin
            sum_s = {1'b0, p_q[2*DATA_W-1:DATA_W]} + {1'b0, mcand};
        end else begin
            sum_s = p_q[2*DATA_W:DATA_W];
        end
        p_step_s  = {1'b0, sum_s, p_q[DATA_W-1:1]};
        prod_next = p_step_s[2*DATA_W-1:0];
        last      = (cnt_q == CNT_W'(mul_pkg::ITER - 1));

        if (load) begin
            p_d   = {{(DATA_W+1){1'b0}}, mplier};
            cnt_d = {CNT_W{1'b0}};
        end else if (step) begin
            p_d   = p_step_s;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            p_d   = p_q;
            cnt_d = cnt_q;
        end
    end

    // Product register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= {(2*DATA_W+1){1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential 32x32 multiplier with register file writeback.
// IDLE -> RUN (32 iterations) -> WB (one-cycle write strobe) -> IDLE.
// Optional feature macro: MUL_SIGNED_EN enables signed operation on
// in_signed (magnitude multiply, negate on RUN->WB, signed overflow rule).
module mul_seq_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    mul_seq_unit_if.slave bus
);
    import mul_pkg::*;

    mul_state_e state_q, state_d;

    logic [DATA_W-1:0]    mcand_q, mcand_d;
    logic [REG_IDX_W-1:0] sc_q, sc_d;
    logic [DATA_W-1:0]    pc_q, pc_d;
    logic [REG_IDX_W-1:0] sc_out_q, sc_out_d;
    logic                 rfl_q, rfl_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic                 load_s, step_s, last_s, ovf_s;
    logic [DATA_W-1:0]    mcand_mag_s, mplier_mag_s;
    logic [2*DATA_W-1:0]  prod_s, final_s;

    mul_shift_add_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .load      (load_s),
        .step      (step_s),
        .mcand     (mcand_q),
        .mplier    (mplier_mag_s),
        .prod_next (prod_s),
        .last      (last_s)
    );

`ifdef MUL_SIGNED_EN
    logic signed_q, signed_d;
    logic neg_q, neg_d;
    logic a_neg_s, b_neg_s;

    // Operand magnitudes, sign capture, result negation and overflow rule.
    always_comb begin
        a_neg_s      = bus.in_signed & bus.in_PA[DATA_W-1];
        b_neg_s      = bus.in_signed & bus.in_PB[DATA_W-1];
        mcand_mag_s  = a_neg_s ? ({DATA_W{1'b0}} - bus.in_PA) : bus.in_PA;
        mplier_mag_s = b_neg_s ? ({DATA_W{1'b0}} - bus.in_PB) : bus.in_PB;
        if (load_s) begin
            signed_d = bus.in_signed;
            neg_d    = a_neg_s ^ b_neg_s;
        end else begin
            signed_d = signed_q;
            neg_d    = neg_q;
        end
        final_s = neg_q ? ({(2*DATA_W){1'b0}} - prod_s) : prod_s;
        if (signed_q) begin
            ovf_s = (final_s[2*DATA_W-1:DATA_W] != {DATA_W{final_s[DATA_W-1]}});
        end else begin
            ovf_s = (final_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
        end
    end

    // Signed-mode capture registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            signed_q <= signed_d;
            neg_q    <= neg_d;
        end
    end
`else
    logic unused_signed_s;
    assign unused_signed_s = bus.in_signed;

    // Unsigned only: operands pass straight through, unsigned overflow rule.
    always_comb begin
        mcand_mag_s  = bus.in_PA;
        mplier_mag_s = bus.in_PB;
        final_s      = prod_s;
        ovf_s        = (final_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
    end
`endif

    // Controller next state, operand capture and writeback outputs.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        sc_d     = sc_q;
        pc_d     = pc_q;
        sc_out_d = sc_out_q;
        rfl_d    = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        load_s   = 1'b0;
        step_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_start) begin
                    state_d = RUN;
                    mcand_d = mcand_mag_s;
                    sc_d    = bus.in_SC;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_d  = WB;
                    pc_d     = final_s[DATA_W-1:0];
                    sc_out_d = sc_q;
                    rfl_d    = (sc_q != R0);
                    done_d   = 1'b1;
                    ovf_d    = ovf_s;
                end else begin
                    state_d = RUN;
                end
            end
            WB: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= {DATA_W{1'b0}};
            sc_q     <= {REG_IDX_W{1'b0}};
            pc_q     <= {DATA_W{1'b0}};
            sc_out_q <= {REG_IDX_W{1'b0}};
            rfl_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            sc_q     <= sc_d;
            pc_q     <= pc_d;
            sc_out_q <= sc_out_d;
            rfl_q    <= rfl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_PC   = pc_q;
    assign bus.out_SC   = sc_out_q;
    assign bus.out_RFL  = rfl_q;
    assign bus.out_busy = busy_q;
    assign bus.out_done = done_q;
    assign bus.out_ovf  = ovf_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit. Stimulus is driven 1 ns after the
// rising edge and outputs are sampled at the same point, so the i-th
// rising edge after the start-sampling edge E0 is reported as index i;
// the writeback cycle is therefore expected at index 32.
module tb_mul_seq_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    mul_seq_unit_if #(.DATA_W(32)) bus();

    mul_seq_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Present one operation and return 1 ns after the edge that samples it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sc, input logic sgn);
        @(posedge clk); #1;
        bus.in_PA = a; bus.in_PB = b; bus.in_SC = sc; bus.in_signed = sgn;
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        bus.in_PA = 32'hA5A5_5A5A; bus.in_PB = 32'h5A5A_A5A5; bus.in_SC = 5'd17;
    endtask

    // Watch n cycles, collecting strobe counts and the values seen with done.
    task automatic observe(input int n, output int rfl_n, output int rfl_idx,
                           output int done_n, output int done_idx,
                           output logic [31:0] pc, output logic [4:0] sc,
                           output logic ovf);
        rfl_n = 0; rfl_idx = -1; done_n = 0; done_idx = -1;
        pc = 32'd0; sc = 5'd0; ovf = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (bus.out_RFL) begin rfl_n++; rfl_idx = i; end
            if (bus.out_done) begin
                done_n++; done_idx = i;
                pc = bus.out_PC; sc = bus.out_SC; ovf = bus.out_ovf;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_start = 1'b0; bus.in_PA = 32'd0; bus.in_PB = 32'd0;
        bus.in_SC = 5'd0; bus.in_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_PC !== 32'd0) begin n_bad++; $display("FAIL rst_pc got %h want 0", bus.out_PC); end
        n_cmp++; if (bus.out_SC !== 5'd0) begin n_bad++; $display("FAIL rst_sc got %h want 0", bus.out_SC); end
        n_cmp++; if (bus.out_RFL !== 1'b0) begin n_bad++; $display("FAIL rst_rfl got %b want 0", bus.out_RFL); end
        n_cmp++; if (bus.out_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.out_busy); end
        n_cmp++; if (bus.out_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.out_done); end
        n_cmp++; if (bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", bus.out_ovf); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_busy !== 1'b0) begin n_bad++; $display("FAIL rel_busy got %b want 0", bus.out_busy); end
        n_cmp++; if (bus.out_RFL !== 1'b0) begin n_bad++; $display("FAIL rel_rfl got %b want 0", bus.out_RFL); end
    endtask

    // Unsigned products, including the two overflowing cases.
    task automatic test_unsigned();
        logic [31:0] va [5] = '{32'd7, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb [5] = '{32'd6, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd2};
        logic [4:0]  vs [5] = '{5'd5, 5'd1, 5'd2, 5'd31, 5'd9};
        logic [31:0] vp [5] = '{32'd42, 32'hFFFE_0001, 32'd0, 32'd1, 32'hFFFF_FFFE};
        logic        vo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int rn, ri, dn, di; logic [31:0] pc; logic [4:0] sc; logic ovf;
        for (int k = 0; k < 5; k++) begin
            start_op(va[k], vb[k], vs[k], 1'b0);
            n_cmp++; if (bus.out_busy !== 1'b1) begin n_bad++; $display("FAIL u%0d_busy_rise got %b want 1", k, bus.out_busy); end
            observe(34, rn, ri, dn, di, pc, sc, ovf);
            n_cmp++; if (dn !== 1 || di !== 32) begin n_bad++; $display("FAIL u%0d_done got n=%0d at %0d want n=1 at 32", k, dn, di); end
            n_cmp++; if (rn !== 1 || ri !== 32) begin n_bad++; $display("FAIL u%0d_rfl got n=%0d at %0d want n=1 at 32", k, rn, ri); end
            n_cmp++; if (pc !== vp[k]) begin n_bad++; $display("FAIL u%0d_pc got %h want %h", k, pc, vp[k]); end
            n_cmp++; if (sc !== vs[k]) begin n_bad++; $display("FAIL u%0d_sc got %0d want %0d", k, sc, vs[k]); end
            n_cmp++; if (ovf !== vo[k]) begin n_bad++; $display("FAIL u%0d_ovf got %b want %b", k, ovf, vo[k]); end
            n_cmp++; if (bus.out_busy !== 1'b0) begin n_bad++; $display("FAIL u%0d_busy_fall got %b want 0", k, bus.out_busy); end
            n_cmp++; if (bus.out_PC !== vp[k] || bus.out_ovf !== vo[k]) begin
                n_bad++; $display("FAIL u%0d_hold got pc=%h ovf=%b want pc=%h ovf=%b", k, bus.out_PC, bus.out_ovf, vp[k], vo[k]);
            end
        end
    endtask

    // Signed requests; overflow expectations depend on the build.
    task automatic test_signed();
        logic [31:0] va [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFE, 32'd7};
        logic [31:0] vb [4] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] vp [4] = '{32'hFFFF_FFF1, 32'h8000_0000, 32'd6, 32'hFFFF_FFF9};
`ifdef MUL_SIGNED_EN
        logic        vo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`else
        logic        vo [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        int rn, ri, dn, di; logic [31:0] pc; logic [4:0] sc; logic ovf;
        for (int k = 0; k < 4; k++) begin
            start_op(va[k], vb[k], 5'd3, 1'b1);
            if (k == 0) begin
                n_cmp++; if (bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_on_start got %b want 0", bus.out_ovf); end
            end
            observe(34, rn, ri, dn, di, pc, sc, ovf);
            n_cmp++; if (di !== 32) begin n_bad++; $display("FAIL s%0d_latency got %0d want 32", k, di); end
            n_cmp++; if (pc !== vp[k]) begin n_bad++; $display("FAIL s%0d_pc got %h want %h", k, pc, vp[k]); end
            n_cmp++; if (ovf !== vo[k]) begin n_bad++; $display("FAIL s%0d_ovf got %b want %b", k, ovf, vo[k]); end
        end
    endtask

    task automatic test_r0();
        int rn, ri, dn, di; logic [31:0] pc; logic [4:0] sc; logic ovf;
        start_op(32'd3, 32'd4, 5'd0, 1'b0);
        observe(34, rn, ri, dn, di, pc, sc, ovf);
        n_cmp++; if (dn !== 1 || di !== 32) begin n_bad++; $display("FAIL r0_done got n=%0d at %0d want n=1 at 32", dn, di); end
        n_cmp++; if (rn !== 0) begin n_bad++; $display("FAIL r0_rfl got %0d strobes want 0", rn); end
        n_cmp++; if (pc !== 32'd12) begin n_bad++; $display("FAIL r0_pc got %h want 0000000c", pc); end
    endtask

    // A start pulse while busy must be dropped, not queued.
    task automatic test_busy_start();
        int rn = 0, dn = 0, rn2, ri2, dn2, di2; logic [31:0] pc = 32'd0, pc2;
        logic [4:0] sc = 5'd0, sc2; logic ovf2;
        start_op(32'd2, 32'd2, 5'd4, 1'b0);
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                bus.in_start = 1'b1; bus.in_PA = 32'd9; bus.in_PB = 32'd9; bus.in_SC = 5'd7;
            end
            if (i == 5) bus.in_start = 1'b0;
            if (bus.out_RFL) rn++;
            if (bus.out_done) begin dn++; pc = bus.out_PC; sc = bus.out_SC; end
        end
        n_cmp++; if (rn !== 1 || dn !== 1) begin n_bad++; $display("FAIL busy_start_count got rfl=%0d done=%0d want 1/1", rn, dn); end
        n_cmp++; if (pc !== 32'd4 || sc !== 5'd4) begin n_bad++; $display("FAIL busy_start_wb got pc=%h sc=%0d want 4/4", pc, sc); end
        observe(40, rn2, ri2, dn2, di2, pc2, sc2, ovf2);
        n_cmp++; if (rn2 !== 0 || dn2 !== 0) begin n_bad++; $display("FAIL busy_start_queued got rfl=%0d done=%0d want 0/0", rn2, dn2); end
    endtask

    // Start held through WB: ignored in WB, accepted one cycle later.
    task automatic test_back_to_back();
        int dn = 0; int di [2] = '{-1, -1}; logic [31:0] pc [2]; logic ovf [2]; logic [4:0] sc [2];
        logic busy33 = 1'b1;
        start_op(32'h0001_2345, 32'h0000_1000, 5'd11, 1'b0);
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk); #1;
            if (i == 32) begin
                bus.in_start = 1'b1; bus.in_PA = 32'h0001_0000; bus.in_PB = 32'h0001_0000; bus.in_SC = 5'd12;
            end
            if (i == 34) bus.in_start = 1'b0;
            if (i == 33) busy33 = bus.out_busy;
            if (bus.out_done) begin
                if (dn < 2) begin di[dn] = i; pc[dn] = bus.out_PC; ovf[dn] = bus.out_ovf; sc[dn] = bus.out_SC; end
                dn++;
            end
        end
        n_cmp++; if (dn !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", dn); end
        n_cmp++; if (busy33 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap got busy=%b want 0", busy33); end
        if (dn >= 2) begin
            n_cmp++; if (di[0] !== 32 || di[1] !== 66) begin n_bad++; $display("FAIL b2b_timing got %0d,%0d want 32,66", di[0], di[1]); end
            n_cmp++; if (pc[0] !== 32'h1234_5000 || ovf[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_first got pc=%h ovf=%b want 12345000/0", pc[0], ovf[0]); end
            n_cmp++; if (pc[1] !== 32'd0 || ovf[1] !== 1'b1 || sc[1] !== 5'd12) begin
                n_bad++; $display("FAIL b2b_second got pc=%h ovf=%b sc=%0d want 0/1/12", pc[1], ovf[1], sc[1]);
            end
        end
    endtask

    // Reset in the middle of RUN abandons the operation.
    task automatic test_reset_mid();
        int rn, ri, dn, di; logic [31:0] pc; logic [4:0] sc; logic ovf;
        start_op(32'd5, 32'd5, 5'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_busy !== 1'b0 || bus.out_RFL !== 1'b0 || bus.out_done !== 1'b0) begin
            n_bad++; $display("FAIL midrst_async got busy=%b rfl=%b done=%b want 0/0/0", bus.out_busy, bus.out_RFL, bus.out_done);
        end
        n_cmp++; if (bus.out_PC !== 32'd0) begin n_bad++; $display("FAIL midrst_pc got %h want 0", bus.out_PC); end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        observe(40, rn, ri, dn, di, pc, sc, ovf);
        n_cmp++; if (rn !== 0 || dn !== 0) begin n_bad++; $display("FAIL midrst_wb got rfl=%0d done=%0d want 0/0", rn, dn); end
        n_cmp++; if (bus.out_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got busy=%b want 0", bus.out_busy); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_r0();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
# mul_seq_unit

Sequential 32×32 shift-add multiplier in the execute/writeback path of the datapath. Consumes two operands read from the register file ports PA/PB, iterates for 32 cycles, then issues a single-cycle write request (PC data, SC select, RFL load) back to the register file. Also reports an overflow flag for the truncated 32-bit result.

## Interface
- `DATA_W`, default 32: operand and result width; only 32 is supported.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.
- `in_clk` input, 1 bit: clock, rising edge.
- `in_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_start` input, 1 bit: starts an operation; sampled only in IDLE.
- `in_PA` input, DATA_W bits: multiplicand, taken from register file port A.
- `in_PB` input, DATA_W bits: multiplier, taken from register file port B.
- `in_SC` input, 5 bits: destination register index, captured together with `in_start`.
- `in_signed` input, 1 bit: signed-operation request; ignored unless `MUL_SIGNED_EN` is defined.
- `out_PC` output, DATA_W bits: low 32 bits of the product, driving the register file write data.
- `out_SC` output, 5 bits: captured destination index.
- `out_RFL` output, 1 bit: register file load strobe.
- `out_busy` output, 1 bit: high in RUN and WB.
- `out_done` output, 1 bit: one-cycle completion pulse.
- `out_ovf` output, 1 bit: product does not fit in 32 bits; held until the next start.

## Operation
- States:
  - IDLE: `in_start`=1 → RUN; captures PA, PB, SC and signed mode, clears the product register and counter, clears `out_ovf`.
  - RUN: 32 iterations; after the counter reaches 31 → WB.
  - WB: exactly one cycle, then → IDLE.
- Iteration, on a 65-bit product register P with initial value {33'b0, multiplier}:
  - If P[0]=1, P[64:32] = P[63:32] + multiplicand (33-bit sum, carry kept).
  - Then P shifts right by 1.
- WB cycle:
  - `out_PC` = P[31:0].
  - `out_RFL` = 1 unless captured SC = 0. R0 is hardwired to zero in the register file, so a write to it is suppressed.
  - `out_done` = 1 regardless of destination.
  - `out_ovf` is set when the upper half is nonzero (unsigned mode) or is not the sign extension of bit 31 (signed mode).
- `in_start` while busy: ignored; no queueing.
- `in_PA`, `in_PB`, `in_SC` may change freely after capture.
- Reset mid-operation: returns to IDLE immediately; no write strobe, no done pulse.

## Timing
- Reset values: all outputs 0, state IDLE.
- `in_start` sampled at edge E0. RUN occupies cycles E0+1 … E0+32. WB occupies cycle E0+33.
- `out_RFL` and `out_done` are high only in cycle E0+33, so the register file captures on the edge ending that cycle.
- Earliest next start is sampled in cycle E0+34, giving a throughput of 1 op per 34 cycles.
- `out_PC` and `out_SC` are registered and hold their last WB values while in IDLE.
- `out_busy` rises in cycle E0+1 and falls after WB.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MUL_SIGNED_EN` defined:
  - When `in_signed`=1, operand magnitudes are multiplied, and the 64-bit product is two's-complement negated at the RUN→WB transition if the operand signs differ.
  - Overflow uses the signed rule.
  - Latency is unchanged.
- `MUL_SIGNED_EN` undefined:
  - `in_signed` is ignored; all operations are unsigned with the unsigned overflow rule.
  - No negation logic is synthesized.

## Structure
- Shared package `mul_pkg` holds:
  - the state enum (IDLE, RUN, WB);
  - the constants DATA_W=32, ITER=32, REG_IDX_W=5 and the zero register index R0=0.
- Sub-module `mul_shift_add_core` holds the product register, adder, shift and iteration counter. The top level holds the FSM, capture registers, writeback and overflow logic.

## Test plan
- Reset: assert `in_rst_n`=0 → all outputs 0. Release → `out_busy`=0 and no strobe.
- 7 × 6, SC=5 → cycle E0+33 shows `out_PC`=42, `out_SC`=5, `out_RFL`=1 for exactly one cycle, `out_ovf`=0.
- 0xFFFFFFFF × 2 unsigned, SC=9 → `out_PC`=0xFFFFFFFE, `out_ovf`=1.
- 0xFFFFFFFD × 5 with `in_signed`=1:
  - Macro defined → `out_PC`=0xFFFFFFF1, `out_ovf`=0.
  - Macro undefined → `out_PC`=0xFFFFFFF1, `out_ovf`=1.
- 3 × 4, SC=0 → `out_done` pulses at E0+33 and `out_RFL` stays 0.
- Start 2 × 2 at SC=4, pulse `in_start` again at E0+5 → the second start is ignored and one writeback of 4 occurs. New start, then `in_rst_n`=0 at E0+10 → no `out_RFL`, no `out_done`, state IDLE.
